// File: rtl/reg_file_2r1w_if.sv
// Bus bundle for reg_file_2r1w: one write port and two read ports.
// REn is sampled on the rising edge. RVALIDn is high for the cycle after an enabled read, and RDATAn holds otherwise.
// There is no backpressure, so every read and write completes on the edge that samples it.
interface reg_file_2r1w_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
);
  logic              WE;
  logic [ADDR_W-1:0] WADDR;
  logic [WIDTH-1:0]  WDATA;
  logic              RE1;
  logic [ADDR_W-1:0] RADDR1;
  logic [WIDTH-1:0]  RDATA1;
  logic              RVALID1;
  logic              RE2;
  logic [ADDR_W-1:0] RADDR2;
  logic [WIDTH-1:0]  RDATA2;
  logic              RVALID2;

  modport master (
    output WE, WADDR, WDATA, RE1, RADDR1, RE2, RADDR2,
    input  RDATA1, RVALID1, RDATA2, RVALID2
  );

  modport slave (
    input  WE, WADDR, WDATA, RE1, RADDR1, RE2, RADDR2,
    output RDATA1, RVALID1, RDATA2, RVALID2
  );
endinterface

// File: rtl/reg_file_2r1w.sv
// Integer register file: one write port and two registered read ports with valid flags.
// It has an optional hardwired-zero register 0, optional same-edge write forwarding, and asynchronous clear.
module reg_file_2r1w #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = (DEPTH > 2) ? $clog2(DEPTH) : 1,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input logic             CLK,
  input logic             nRST,
  reg_file_2r1w_if.slave  bus
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [WIDTH-1:0] rdata1_q, rdata1_d, rdata2_q, rdata2_d;
  logic             rvalid1_q, rvalid1_d, rvalid2_q, rvalid2_d;
  logic             wr_ok;
  logic [WIDTH-1:0] stored1, stored2;

  // A write counts only if it is in range and does not target a hardwired zero register.
  assign wr_ok = bus.WE && ({1'b0, bus.WADDR} < DEPTH_L) &&
                 !((ZERO_REG != 0) && (bus.WADDR == '0));

  function automatic logic [WIDTH-1:0] pick(
    input logic [ADDR_W-1:0] ra,
    input logic [WIDTH-1:0]  stored,
    input logic              hit_ok,
    input logic [ADDR_W-1:0] wa,
    input logic [WIDTH-1:0]  wd
  );
    logic [WIDTH-1:0] v;
    v = stored;
    if ({1'b0, ra} >= DEPTH_L) begin
      v = '0;
    end else if ((ZERO_REG != 0) && (ra == '0)) begin
      v = '0;
    end else if ((BYPASS != 0) && hit_ok && (wa == ra)) begin
      v = wd;
    end
    return v;
  endfunction

  always_comb begin
    mem_d   = mem_q;
    stored1 = '0;
    stored2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_ok && (bus.WADDR == ADDR_W'(i))) mem_d[i] = bus.WDATA;
      if (bus.RADDR1 == ADDR_W'(i)) stored1 = mem_q[i];
      if (bus.RADDR2 == ADDR_W'(i)) stored2 = mem_q[i];
    end
  end

  always_comb begin
    rdata1_d  = rdata1_q;
    rdata2_d  = rdata2_q;
    rvalid1_d = bus.RE1;
    rvalid2_d = bus.RE2;
    if (bus.RE1) rdata1_d = pick(bus.RADDR1, stored1, wr_ok, bus.WADDR, bus.WDATA);
    if (bus.RE2) rdata2_d = pick(bus.RADDR2, stored2, wr_ok, bus.WADDR, bus.WDATA);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rdata1_q  <= '0;
      rdata2_q  <= '0;
      rvalid1_q <= 1'b0;
      rvalid2_q <= 1'b0;
    end else begin
      mem_q     <= mem_d;
      rdata1_q  <= rdata1_d;
      rdata2_q  <= rdata2_d;
      rvalid1_q <= rvalid1_d;
      rvalid2_q <= rvalid2_d;
    end
  end

  assign bus.RDATA1  = rdata1_q;
  assign bus.RVALID1 = rvalid1_q;
  assign bus.RDATA2  = rdata2_q;
  assign bus.RVALID2 = rvalid2_q;

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Bench for reg_file_2r1w: a default build (A) and a DEPTH=24, ZERO_REG=0, BYPASS=0 build (B).
// Both builds receive the same stimulus, and each has its own expected values.
module tb_reg_file_2r1w;

  localparam int W = 32;

  logic clk;
  logic n_rst;
  int   checks;
  int   failures;
  logic [W-1:0] exp_q[$];

  reg_file_2r1w_if #(.WIDTH(32), .ADDR_W(5)) if_a ();
  reg_file_2r1w_if #(.WIDTH(32), .ADDR_W(5)) if_b ();

  reg_file_2r1w #(.WIDTH(32), .DEPTH(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) u_a (
    .CLK (clk),
    .nRST(n_rst),
    .bus (if_a)
  );

  reg_file_2r1w #(.WIDTH(32), .DEPTH(24), .ADDR_W(5), .ZERO_REG(0), .BYPASS(0)) u_b (
    .CLK (clk),
    .nRST(n_rst),
    .bus (if_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        re1;
    logic [4:0]  ra1;
    logic        re2;
    logic [4:0]  ra2;
    logic [31:0] a1;
    logic        av1;
    logic [31:0] a2;
    logic        av2;
    logic [31:0] b1;
    logic        bv1;
    logic [31:0] b2;
    logic        bv2;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs [NV];

  task automatic set_in(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic re1, input logic [4:0] ra1,
                        input logic re2, input logic [4:0] ra2);
    if_a.WE = we;  if_a.WADDR = wa;  if_a.WDATA = wd;
    if_a.RE1 = re1; if_a.RADDR1 = ra1; if_a.RE2 = re2; if_a.RADDR2 = ra2;
    if_b.WE = we;  if_b.WADDR = wa;  if_b.WDATA = wd;
    if_b.RE1 = re1; if_b.RADDR1 = ra1; if_b.RE2 = re2; if_b.RADDR2 = ra2;
  endtask

  task automatic cmp(input string tag, input logic [W-1:0] act);
    logic [W-1:0] exp;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL %s scoreboard empty, got=%h", tag, act);
    end else begin
      exp = exp_q.pop_front();
      if (act !== exp) begin
        failures++;
        $display("FAIL %s got=%h exp=%h", tag, act, exp);
      end
    end
  endtask

  task automatic check_all(input string tag,
                           input logic [31:0] a1, input logic av1, input logic [31:0] a2, input logic av2,
                           input logic [31:0] b1, input logic bv1, input logic [31:0] b2, input logic bv2);
    exp_q.push_back(a1); exp_q.push_back(32'(av1));
    exp_q.push_back(a2); exp_q.push_back(32'(av2));
    exp_q.push_back(b1); exp_q.push_back(32'(bv1));
    exp_q.push_back(b2); exp_q.push_back(32'(bv2));
    cmp({tag, ".a.rdata1"},  if_a.RDATA1);
    cmp({tag, ".a.rvalid1"}, 32'(if_a.RVALID1));
    cmp({tag, ".a.rdata2"},  if_a.RDATA2);
    cmp({tag, ".a.rvalid2"}, 32'(if_a.RVALID2));
    cmp({tag, ".b.rdata1"},  if_b.RDATA1);
    cmp({tag, ".b.rvalid1"}, 32'(if_b.RVALID1));
    cmp({tag, ".b.rdata2"},  if_b.RDATA2);
    cmp({tag, ".b.rvalid2"}, 32'(if_b.RVALID2));
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    //          we    wa     wd            re1  ra1   re2  ra2    A: rd1 v1 rd2 v2                         B: rd1 v1 rd2 v2
    vecs[0]  = '{1'b1, 5'd7,  32'hDEADBEEF, 1'b0, 5'd0,  1'b0, 5'd0,  32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0};
    vecs[1]  = '{1'b1, 5'd9,  32'h12345678, 1'b0, 5'd0,  1'b0, 5'd0,  32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0};
    vecs[2]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  1'b1, 5'd9,  32'hDEADBEEF, 1'b1, 32'h12345678, 1'b1, 32'hDEADBEEF, 1'b1, 32'h12345678, 1'b1};
    vecs[3]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 1'b0, 5'd0,  1'b0, 5'd0,  32'hDEADBEEF, 1'b0, 32'h12345678, 1'b0, 32'hDEADBEEF, 1'b0, 32'h12345678, 1'b0};
    vecs[4]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  1'b1, 5'd0,  32'h0, 1'b1, 32'h0, 1'b1, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1};
    vecs[5]  = '{1'b1, 5'd3,  32'h11,       1'b0, 5'd0,  1'b0, 5'd0,  32'h0, 1'b0, 32'h0, 1'b0, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFF, 1'b0};
    vecs[6]  = '{1'b1, 5'd3,  32'h22,       1'b1, 5'd3,  1'b0, 5'd0,  32'h22, 1'b1, 32'h0, 1'b0, 32'h11, 1'b1, 32'hFFFFFFFF, 1'b0};
    vecs[7]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd3,  1'b1, 5'd3,  32'h22, 1'b1, 32'h22, 1'b1, 32'h22, 1'b1, 32'h22, 1'b1};
    vecs[8]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  1'b0, 5'd0,  32'hDEADBEEF, 1'b1, 32'h22, 1'b0, 32'hDEADBEEF, 1'b1, 32'h22, 1'b0};
    vecs[9]  = '{1'b1, 5'd7,  32'hCAFEF00D, 1'b0, 5'd7,  1'b0, 5'd0,  32'hDEADBEEF, 1'b0, 32'h22, 1'b0, 32'hDEADBEEF, 1'b0, 32'h22, 1'b0};
    vecs[10] = '{1'b1, 5'd7,  32'h01010101, 1'b0, 5'd7,  1'b0, 5'd0,  32'hDEADBEEF, 1'b0, 32'h22, 1'b0, 32'hDEADBEEF, 1'b0, 32'h22, 1'b0};
    vecs[11] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd7,  1'b0, 5'd0,  32'hDEADBEEF, 1'b0, 32'h22, 1'b0, 32'hDEADBEEF, 1'b0, 32'h22, 1'b0};
    vecs[12] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  1'b1, 5'd9,  32'h01010101, 1'b1, 32'h12345678, 1'b1, 32'h01010101, 1'b1, 32'h12345678, 1'b1};
    vecs[13] = '{1'b1, 5'd30, 32'hABCD1234, 1'b0, 5'd0,  1'b0, 5'd0,  32'h01010101, 1'b0, 32'h12345678, 1'b0, 32'h01010101, 1'b0, 32'h12345678, 1'b0};
    vecs[14] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd30, 1'b1, 5'd23, 32'hABCD1234, 1'b1, 32'h0, 1'b1, 32'h0, 1'b1, 32'h0, 1'b1};
    vecs[15] = '{1'b1, 5'd23, 32'h5A5A5A5A, 1'b1, 5'd23, 1'b1, 5'd23, 32'h5A5A5A5A, 1'b1, 32'h5A5A5A5A, 1'b1, 32'h0, 1'b1, 32'h0, 1'b1};
    vecs[16] = '{1'b1, 5'd30, 32'h77,       1'b1, 5'd30, 1'b1, 5'd23, 32'h77, 1'b1, 32'h5A5A5A5A, 1'b1, 32'h0, 1'b1, 32'h5A5A5A5A, 1'b1};
    vecs[17] = '{1'b1, 5'd0,  32'h1234,     1'b1, 5'd0,  1'b1, 5'd31, 32'h0, 1'b1, 32'h0, 1'b1, 32'hFFFFFFFF, 1'b1, 32'h0, 1'b1};
    vecs[18] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  1'b1, 5'd30, 32'h0, 1'b1, 32'h77, 1'b1, 32'h1234, 1'b1, 32'h0, 1'b1};

    // Hold reset low across two edges, then check the cleared outputs.
    n_rst = 1'b0;
    set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    check_all("reset", 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    n_rst = 1'b1;

    for (int i = 0; i < NV; i++) begin
      set_in(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].re1, vecs[i].ra1, vecs[i].re2, vecs[i].ra2);
      @(posedge clk);
      #1;
      check_all($sformatf("vec%0d", i), vecs[i].a1, vecs[i].av1, vecs[i].a2, vecs[i].av2,
                vecs[i].b1, vecs[i].bv1, vecs[i].b2, vecs[i].bv2);
      @(negedge clk);
    end

    // Assert reset in the middle of a cycle: outputs must clear with no clock edge.
    set_in(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 1'b1, 5'd9);
    @(posedge clk);
    #1;
    check_all("pre_rst", 32'h01010101, 1'b1, 32'h12345678, 1'b1, 32'h01010101, 1'b1, 32'h12345678, 1'b1);
    @(negedge clk);
    set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0);
    #2;
    n_rst = 1'b0;
    #1;
    check_all("async_rst", 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    n_rst = 1'b1;
    set_in(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b1, 5'd30);
    @(posedge clk);
    #1;
    check_all("post_rst_read", 32'h0, 1'b1, 32'h0, 1'b1, 32'h0, 1'b1, 32'h0, 1'b1);

    // A write that is in flight when reset asserts must be discarded.
    @(negedge clk);
    set_in(1'b1, 5'd4, 32'h44444444, 1'b0, 5'd0, 1'b0, 5'd0);
    @(posedge clk);
    @(negedge clk);
    set_in(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 1'b0, 5'd0);
    @(posedge clk);
    #1;
    check_all("reg4_written", 32'h44444444, 1'b1, 32'h0, 1'b0, 32'h44444444, 1'b1, 32'h0, 1'b0);
    @(negedge clk);
    set_in(1'b1, 5'd4, 32'h55555555, 1'b1, 5'd4, 1'b0, 5'd0);
    n_rst = 1'b0;
    #1;
    check_all("rst_with_we", 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    n_rst = 1'b1;
    set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0);
    @(posedge clk);
    #1;
    check_all("idle_after_rst", 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    set_in(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 1'b1, 5'd4);
    @(posedge clk);
    #1;
    check_all("reg4_cleared", 32'h0, 1'b1, 32'h0, 1'b1, 32'h0, 1'b1, 32'h0, 1'b1);
    @(negedge clk);
    set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_file_2r1w.md
Name: reg_file_2r1w

Overview:
- Parametrised register file with one write port and two independent registered read ports.
- Generalises the single-bit latch cell with two tristate read ports to WIDTH x DEPTH storage.
- Adds synchronous read enables with valid flags, optional write-to-read bypass, optional hardwired-zero register 0, and asynchronous clear.
- Sits in the CPU datapath as the integer register file; RDATA1/RDATA2 feed the operand latches.

Parameters:
- WIDTH, 32, data bits per register
- DEPTH, 32, number of registers (any value >= 2, need not be a power of two)
- ADDR_W, $clog2(DEPTH), address width; minimum 1
- ZERO_REG, 1, when 1 register 0 reads as zero and ignores writes
- BYPASS, 1, when 1 a same-edge write to the read address is forwarded to the read port

Ports:
- CLK  input  1  system clock, all state updates on rising edge
- nRST  input  1  asynchronous active-low reset
- WE  input  1  write enable
- WADDR  input  ADDR_W  write address
- WDATA  input  WIDTH  write data
- RE1  input  1  read enable, port 1
- RADDR1  input  ADDR_W  read address, port 1
- RDATA1  output  WIDTH  registered read data, port 1
- RVALID1  output  1  RDATA1 was updated by the previous edge
- RE2  input  1  read enable, port 2
- RADDR2  input  ADDR_W  read address, port 2
- RDATA2  output  WIDTH  registered read data, port 2
- RVALID2  output  1  RDATA2 was updated by the previous edge

Behaviour:
- Reset:
  - nRST low immediately, without waiting for CLK, clears every storage word and forces RDATA1, RDATA2, RVALID1 and RVALID2 to 0.
  - Clearing is held while nRST stays low.
  - Deassertion takes effect at the next rising CLK.
  - Reset during an operation discards any in-flight read or write.
- Write:
  - On a rising edge with WE=1, storage[WADDR] <= WDATA.
  - The write is ignored when WADDR >= DEPTH.
  - The write is ignored when ZERO_REG=1 and WADDR=0.
- Read:
  - Latency is 1 cycle.
  - On a rising edge with REn=1, RDATAn <= the selected word and RVALIDn <= 1.
  - On an edge with REn=0, RDATAn holds its previous value and RVALIDn <= 0.
  - This hold replaces the old tristate-off; no Z is ever driven.
- Read value selection, highest priority first:
  1. RADDRn >= DEPTH gives 0.
  2. ZERO_REG=1 and RADDRn=0 gives 0.
  3. BYPASS=1, WE=1 and WADDR=RADDRn with the write accepted gives WDATA.
  4. Otherwise gives storage[RADDRn] as it was before the edge.
- Simultaneous events:
  - Both ports may read the same address on the same edge; both return identical data.
  - Read and write to the same address with BYPASS=0 returns the old value; the new value is visible from the next read onward.
  - Read data never depends on a write rejected by the range or zero rules.
- No combinational path from any input to any output; all outputs come from flops.
- Arithmetic: address compares are unsigned on ADDR_W bits. No width conversion on data.

Test Plan:
- Reset then read: pulse nRST low mid-cycle, then RE1=1 RADDR1=5 -> RDATA1 goes to 0 without a CLK edge during reset; one cycle after the read, RDATA1=0 and RVALID1=1.
- Write then dual read: write 0xDEADBEEF to reg 7 and 0x12345678 to reg 9, then RE1/RE2 on 7/9 -> next cycle RDATA1=0xDEADBEEF, RDATA2=0x12345678, both RVALID=1.
- Zero register: WE=1 WADDR=0 WDATA=0xFFFFFFFF, then read reg 0 on both ports -> RDATA=0 with ZERO_REG=1; RDATA=0xFFFFFFFF when rebuilt with ZERO_REG=0.
- Bypass: reg 3 holds 0x11; on one edge WE=1 WADDR=3 WDATA=0x22 with RE1=1 RADDR1=3 -> RDATA1=0x22 with BYPASS=1, 0x11 with BYPASS=0; a following read returns 0x22 in both builds.
- Hold and range:
  - Read reg 7, then deassert RE1 for 3 cycles while writing reg 7 -> RDATA1 stays at the old value and RVALID1=0 throughout.
  - With DEPTH=24, write and read address 30 -> write ignored, RDATA=0.
- Reset mid-operation: assert nRST low on the same cycle as WE=1 WADDR=4 -> reg 4 reads 0 after reset; all RVALID=0 until the first enabled read.
